// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipeline hazard controller.
//   stage_rec_t  - in-flight destination record held for stages EXE..WB
//   FWD_REGFILE  - forward code meaning "take the operand from the regfile"
//   safe_clog2() - clog2 that never returns a zero width
package pipe_pkg;

  // Record register field is sized for the widest register file we expect;
  // narrower register numbers are zero-extended into it.
  localparam int RN_MAX_W    = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                valid;
    logic                wreg;
    logic                m2reg;
    logic                mem_op;   // load or store, may wait on mem_ready
    logic [RN_MAX_W-1:0] rn;
  } stage_rec_t;

  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// pipe_fwd_match: operand source resolution for one ID source register.
// Scans the in-flight records and reports the youngest producer.
//   recs     in  records for stages 2..NSTAGE-1
//   src      in  source register number
//   use_src  in  instruction actually reads src
//   id_valid in  ID holds a real instruction
//   hit      out some stage will write src
//   load_hit out youngest producer is a load not yet past MEM-1 (must stall)
//   code     out forward code: 0 = regfile, k = result of stage k+1
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int RNW    = 5,
  parameter int FW     = 2
) (
  input  stage_rec_t [NSTAGE-1:2] recs,
  input  logic [RNW-1:0]          src,
  input  logic                    use_src,
  input  logic                    id_valid,
  output logic                    hit,
  output logic                    load_hit,
  output logic [FW-1:0]           code
);

  logic [RN_MAX_W-1:0] src_x;
  assign src_x = RN_MAX_W'(src);

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit      = 1'b0;
    load_hit = 1'b0;
    code     = FW'(FWD_REGFILE);
    for (int s = NSTAGE-1; s >= 2; s--) begin
      if (recs[s].valid && recs[s].wreg && (recs[s].rn == src_x) &&
          (recs[s].rn != '0) && use_src && id_valid) begin
        hit      = 1'b1;
        // A load's data exists only once it has left MEM.
        load_hit = recs[s].m2reg && (s <= NSTAGE-3);
        // WB writes the regfile on the falling edge, so it needs no forward.
        code     = (s <= NSTAGE-2) ? FW'(s-1) : FW'(FWD_REGFILE);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/sequencing control for an NSTAGE in-order pipeline.
// Tracks destination records EXE..WB and derives forwarding, load-use stall,
// taken-branch squash and memory-wait freeze. All control outputs are
// combinational from the records and current inputs.
// Optional macro PIPE_PERF_CNT_EN builds retire/stall counters; without it
// ret_cnt/stall_cnt are tied to zero.
//   clock, resetn        pipeline clock, async active-low reset
//   id_*                 decoded ID-stage instruction fields
//   mem_ready            data memory completes this cycle
//   wpcir                0 holds PC and IF/ID
//   dbubble              squash IF/ID at the next edge (taken branch)
//   ebubble              ID/EXE loads a bubble (load-use)
//   fwd_a, fwd_b         operand source for rs / rt
//   stage_en             per-stage advance enable
//   ret_cnt, stall_cnt   performance counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int NREG   = 32,
  parameter int RNW    = $clog2(NREG),
  parameter int FW     = safe_clog2(NSTAGE-2),
  parameter int CNTW   = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [RNW-1:0]    id_rs,
  input  logic [RNW-1:0]    id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              id_wmem,
  input  logic [RNW-1:0]    id_rn,
  input  logic              id_branch_taken,
  input  logic              mem_ready,
  output logic              wpcir,
  output logic              dbubble,
  output logic              ebubble,
  output logic [FW-1:0]     fwd_a,
  output logic [FW-1:0]     fwd_b,
  output logic [NSTAGE-1:0] stage_en,
  output logic [CNTW-1:0]   ret_cnt,
  output logic [CNTW-1:0]   stall_cnt
);

  stage_rec_t [NSTAGE-1:2] rec;
  stage_rec_t              id_rec;

  logic [1:0]          hit, load_hit, use_src;
  logic [1:0][RNW-1:0] src;
  logic [1:0][FW-1:0]  code;
  logic                luse, freeze;

  assign src     = {id_rt, id_rs};
  assign use_src = {id_use_rt, id_use_rs};

  for (genvar g = 0; g < 2; g++) begin : g_op
    pipe_fwd_match #(.NSTAGE(NSTAGE), .RNW(RNW), .FW(FW)) u_match (
      .recs     (rec),
      .src      (src[g]),
      .use_src  (use_src[g]),
      .id_valid (id_valid),
      .hit      (hit[g]),
      .load_hit (load_hit[g]),
      .code     (code[g])
    );
  end

  assign luse   = |(hit & load_hit);
  assign freeze = rec[NSTAGE-2].valid & rec[NSTAGE-2].mem_op & ~mem_ready;
  assign fwd_a  = code[0];
  assign fwd_b  = code[1];

  assign id_rec = '{valid:  id_valid,
                    wreg:   id_wreg,
                    m2reg:  id_m2reg,
                    mem_op: id_m2reg | id_wmem,
                    rn:     RN_MAX_W'(id_rn)};

  // Freeze dominates; a branch under load-use waits for ID to re-present it.
  always_comb begin
    wpcir    = 1'b1;
    ebubble  = 1'b0;
    dbubble  = 1'b0;
    stage_en = '1;
    if (freeze) begin
      wpcir    = 1'b0;
      stage_en = '0;
    end else if (luse) begin
      wpcir         = 1'b0;
      ebubble       = 1'b1;
      stage_en[1:0] = 2'b00;
    end else begin
      dbubble = id_branch_taken & id_valid;
    end
    // Records are already clear in reset; only the branch path sees raw inputs.
    if (!resetn) dbubble = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rec <= '0;
    end else if (!freeze) begin
      rec[2] <= luse ? '0 : id_rec;
      for (int s = 3; s < NSTAGE; s++) rec[s] <= rec[s-1];
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNTW-1:0] ret_q, stall_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ret_q   <= '0;
      stall_q <= '0;
    end else begin
      if (rec[NSTAGE-1].valid && stage_en[NSTAGE-1]) ret_q <= ret_q + CNTW'(1);
      if (!wpcir) stall_q <= stall_q + CNTW'(1);
    end
  end

  assign ret_cnt   = ret_q;
  assign stall_cnt = stall_q;
`else
  assign ret_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (NSTAGE=5 and NSTAGE=6) share one
// stimulus stream. A behavioural model tracks the instruction occupying each
// stage and predicts the control outputs; predictions are queued and a
// separate monitor compares them against the DUTs each cycle.
module tb_pipe_hazard_ctrl;

  localparam int RNW = 5;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_wreg = 0;
  logic id_m2reg = 0, id_wmem = 0, id_branch_taken = 0, mem_ready = 1;
  logic [RNW-1:0] id_rs = '0, id_rt = '0, id_rn = '0;

  logic        wpcir_o[2], dbub_o[2], ebub_o[2];
  logic [1:0]  fa_o[2], fb_o[2];
  logic [31:0] rc_o[2], sc_o[2];
  logic [4:0]  se5;
  logic [5:0]  se6;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.NSTAGE(5)) u_dut5 (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wmem(id_wmem), .id_rn(id_rn), .id_branch_taken(id_branch_taken), .mem_ready(mem_ready),
    .wpcir(wpcir_o[0]), .dbubble(dbub_o[0]), .ebubble(ebub_o[0]), .fwd_a(fa_o[0]), .fwd_b(fb_o[0]),
    .stage_en(se5), .ret_cnt(rc_o[0]), .stall_cnt(sc_o[0]));

  pipe_hazard_ctrl #(.NSTAGE(6)) u_dut6 (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_wmem(id_wmem), .id_rn(id_rn), .id_branch_taken(id_branch_taken), .mem_ready(mem_ready),
    .wpcir(wpcir_o[1]), .dbubble(dbub_o[1]), .ebubble(ebub_o[1]), .fwd_a(fa_o[1]), .fwd_b(fb_o[1]),
    .stage_en(se6), .ret_cnt(rc_o[1]), .stall_cnt(sc_o[1]));

  // One in-flight instruction as the model sees it.
  typedef struct { bit v; bit w; bit ld; bit mo; int rn; } ins_t;
  typedef struct {
    int inst; bit luse; bit wpcir; bit dbub; bit ebub;
    int fa; int fb; int se; int unsigned rc; int unsigned sc;
  } exp_t;

  ins_t        m[2][8];    // m[i][s]: instruction in stage s of instance i
  int unsigned rc_m[2], sc_m[2];
  exp_t        q[$];
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic void clear_model(input int i);
    for (int s = 0; s < 8; s++) m[i][s] = '{0, 0, 0, 0, 0};
    rc_m[i] = 0;
    sc_m[i] = 0;
  endfunction

  // Nearest older instruction writing src decides where the operand comes from.
  function automatic void lookup(input int i, input int src, input bit use_src,
                                 output int code, output bit ld);
    int ns = 5 + i;
    code = 0;
    ld   = 0;
    if (!use_src || !id_valid || src == 0) return;
    for (int s = 2; s < ns; s++) begin
      if (m[i][s].v && m[i][s].w && m[i][s].rn == src) begin
        code = (s <= ns-2) ? s-1 : 0;
        ld   = m[i][s].ld && (s <= ns-3);
        return;
      end
    end
  endfunction

  function automatic exp_t predict(input int i);
    exp_t e;
    int   ns = 5 + i;
    int   all = (1 << ns) - 1;
    bit   la, lb, frz;
    e.inst = i;
    lookup(i, int'(id_rs), id_use_rs, e.fa, la);
    lookup(i, int'(id_rt), id_use_rt, e.fb, lb);
    e.luse  = la | lb;
    frz     = m[i][ns-2].v && m[i][ns-2].mo && !mem_ready;
    e.wpcir = !(e.luse || frz);
    e.ebub  = e.luse && !frz;
    e.dbub  = id_branch_taken && id_valid && !e.luse && !frz && resetn;
    e.se    = frz ? 0 : (e.luse ? (all & ~3) : all);
    e.rc    = rc_m[i];
    e.sc    = sc_m[i];
    return e;
  endfunction

  function automatic void advance(input int i, input exp_t e);
    int ns = 5 + i;
    if (!resetn) begin
      clear_model(i);
      return;
    end
`ifdef PIPE_PERF_CNT_EN
    if (m[i][ns-1].v && e.se != 0) rc_m[i]++;
    if (!e.wpcir) sc_m[i]++;
`endif
    if (e.se == 0) return;   // memory wait: nothing moves
    for (int s = ns-1; s >= 3; s--) m[i][s] = m[i][s-1];
    m[i][2] = e.luse ? '{0, 0, 0, 0, 0} : '{id_valid, id_wreg, id_m2reg, id_m2reg | id_wmem, int'(id_rn)};
  endfunction

  // One pipeline cycle: drive at the falling edge, predict, commit after the rising edge.
  task automatic cyc(input bit rst, input bit v, input int rs, input bit urs, input int rt,
                     input bit urt, input bit w, input bit ld, input bit st, input int rn,
                     input bit br, input bit rdy);
    exp_t e[2];
    @(negedge clock);
    resetn = rst; id_valid = v; id_rs = RNW'(rs); id_use_rs = urs; id_rt = RNW'(rt);
    id_use_rt = urt; id_wreg = w; id_m2reg = ld; id_wmem = st; id_rn = RNW'(rn);
    id_branch_taken = br; mem_ready = rdy;
    for (int i = 0; i < 2; i++) begin
      if (!rst) clear_model(i);
      e[i] = predict(i);
      q.push_back(e[i]);
    end
    @(posedge clock);
    for (int i = 0; i < 2; i++) advance(i, e[i]);
  endtask

  task automatic ins(input int rs, input bit urs, input int rt, input bit urt, input bit w,
                     input bit ld, input bit st, input int rn, input bit br, input bit rdy);
    cyc(1, 1, rs, urs, rt, urt, w, ld, st, rn, br, rdy);
  endtask

  task automatic nop(input bit rdy);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  // Monitor: compare everything queued for this cycle once inputs have settled.
  always @(negedge clock) begin
    exp_t  e;
    string p;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      p = $sformatf("ns%0d_", 5 + e.inst);
      chk({p, "wpcir"},    wpcir_o[e.inst], e.wpcir);
      chk({p, "dbubble"},  dbub_o[e.inst],  e.dbub);
      chk({p, "ebubble"},  ebub_o[e.inst],  e.ebub);
      chk({p, "stage_en"}, (e.inst == 0) ? longint'(se5) : longint'(se6), e.se);
      chk({p, "ret_cnt"},  rc_o[e.inst],    e.rc);
      chk({p, "stall_cnt"}, sc_o[e.inst],   e.sc);
      if (!e.luse) begin
        chk({p, "fwd_a"}, fa_o[e.inst], e.fa);
        chk({p, "fwd_b"}, fb_o[e.inst], e.fb);
      end
    end
  end

  initial begin
    clear_model(0);
    clear_model(1);
    #1 resetn = 1'b0;
    // Reset with live inputs, including a taken branch that must not leak out.
    for (int k = 0; k < 3; k++) cyc(0, 1, 3, 1, 4, 1, 1, 1, 0, 3, 1, 0);
    // add r3 then two readers of r3: forward from EXE, then MEM.
    ins(1, 1, 2, 1, 1, 0, 0, 3, 0, 1);
    ins(3, 1, 0, 0, 1, 0, 0, 6, 0, 1);
    ins(3, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    // lw r4, reader of rt=r4 stalls once, then re-presented reader forwards.
    ins(1, 1, 0, 0, 1, 1, 0, 4, 0, 1);
    ins(0, 0, 4, 1, 1, 0, 0, 7, 0, 1);
    ins(0, 0, 4, 1, 1, 0, 0, 7, 0, 1);
    // r0 writer and reader: never forwarded.
    ins(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    ins(0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    // r5 written twice: youngest wins.
    ins(0, 0, 0, 0, 1, 0, 0, 5, 0, 1);
    ins(0, 0, 0, 0, 1, 0, 0, 5, 0, 1);
    ins(5, 1, 5, 1, 0, 0, 0, 0, 0, 1);
    // Store reaches MEM and waits; taken branch in ID held until release.
    ins(2, 1, 3, 1, 0, 0, 1, 0, 0, 1);
    nop(1);
    for (int k = 0; k < 3; k++) ins(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    ins(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    ins(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // Taken branch, no hazard.
    ins(9, 1, 10, 1, 0, 0, 0, 0, 1, 1);
    nop(1);
    // Reset dropped while frozen.
    ins(0, 0, 0, 0, 0, 1, 0, 8, 0, 1);
    nop(1);
    nop(0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(1);
    // Deeper pipe: producer at each distance, and a load two stages ahead.
    ins(0, 0, 0, 0, 1, 0, 0, 7, 0, 1);
    nop(1);
    nop(1);
    ins(7, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    ins(0, 0, 0, 0, 1, 1, 0, 9, 0, 1);
    nop(1);
    ins(9, 1, 9, 1, 0, 0, 0, 0, 0, 1);
    ins(9, 1, 9, 1, 0, 0, 0, 0, 0, 1);
    // Randomised traffic over a small register window to provoke hazards.
    for (int k = 0; k < 600; k++) begin
      bit ld = ($urandom_range(0, 3) == 0);
      cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 7) != 0),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
          ld | ($urandom_range(0, 1) == 1), ld, !ld && ($urandom_range(0, 4) == 0),
          $urandom_range(0, 7), ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
    end
    nop(1);
    @(negedge clock);
    #5;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
